// File: rtl/fpu_pack.sv
// fpu_pack: packs sign / biased exponent / guarded mantissa into an IEEE-754 word,
// normalizing one bit per cycle and rounding to nearest-even. Define FPU_PACK_FTZ_EN to flush denormals to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | in_ready=1, waiting for an operand
// S_NORM  | one normalization shift per cycle (right for tiny e, left for unnormalized m)
// S_ROUND | round to nearest-even, detect overflow/underflow, build the result
// S_DONE  | out_valid=1, result held until out_ready
module fpu_pack #(
  parameter int BITNESS = 64,
  localparam int EXP_W  = (BITNESS == 16) ? 5  : (BITNESS == 32) ? 8  : (BITNESS == 64) ? 11 : 15,
  localparam int MANT_W = (BITNESS == 16) ? 11 : (BITNESS == 32) ? 24 : (BITNESS == 64) ? 53 : 113
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W+1:0]    in_exp,
  input  logic [MANT_W+2:0]   in_mant,
  input  logic                in_nan,
  input  logic                in_inf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITNESS-1:0]  out_number,
  output logic [2:0]          out_flags
);

  localparam int EW = EXP_W + 2;
  localparam int MW = MANT_W + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MIN  = EW'(-(MANT_W + 2));
  localparam logic signed [EW:0]   EX_ONE = (EW + 1)'(1);
  localparam logic signed [EW:0]   E_MAX  = (EW + 1)'((1 << EXP_W) - 1);

  logic [1:0]              state;
  logic [MW-1:0]           m;
  logic signed [EW-1:0]    e;
  logic                    sign;

  logic [MW-1:0]           m_nx;
  logic signed [EW-1:0]    e_nx;
  logic                    norm_done;

  logic [BITNESS-1:0]      spec_num;

  logic [MANT_W-1:0]       sig;
  logic                    g_bit, r_bit, s_bit, lsb_bit, rnd_up, inexact;
  logic [MANT_W:0]         sum;
  logic [MANT_W-1:0]       sig_r;
  logic signed [EW:0]      e_ext, e_r;
  logic [BITNESS-1:0]      rnd_num;
  logic [2:0]              rnd_flags;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Special operands bypass normalization; NaN wins over infinity, then zero.
  always_comb begin
    spec_num = '0;
    if (in_nan)
      spec_num = {in_sign, {EXP_W{1'b1}}, 1'b1, {(MANT_W-2){1'b0}}};
    else if (in_inf)
      spec_num = {in_sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
    else
      spec_num = {in_sign, {(BITNESS-1){1'b0}}};
  end

  // One normalization step; very small exponents collapse straight into sticky.
  always_comb begin
    m_nx      = m;
    e_nx      = e;
    norm_done = 1'b0;
    if (e < E_MIN) begin
      m_nx = {{(MW-1){1'b0}}, |m};
      e_nx = E_ONE;
    end else if (e < E_ONE) begin
      m_nx = {1'b0, m[MW-1:2], m[1] | m[0]};
      e_nx = e + E_ONE;
    end else if (!m[MW-1] && (e > E_ONE)) begin
      m_nx = {m[MW-2:0], 1'b0};
      e_nx = e - E_ONE;
    end else begin
      norm_done = 1'b1;
    end
  end

  always_comb begin
    sig     = m[MW-1:3];
    g_bit   = m[2];
    r_bit   = m[1];
    s_bit   = m[0];
    lsb_bit = m[3];
    rnd_up  = g_bit & (r_bit | s_bit | lsb_bit);
    inexact = g_bit | r_bit | s_bit;
    sum     = {1'b0, sig} + {{MANT_W{1'b0}}, rnd_up};
    e_ext   = {e[EW-1], e};
    if (sum[MANT_W]) begin
      sig_r = sum[MANT_W:1];
      e_r   = e_ext + EX_ONE;
    end else begin
      sig_r = sum[MANT_W-1:0];
      e_r   = e_ext;
    end
  end

  // A denormal rounding up into the hidden bit becomes the smallest normal (e is 1 there).
  always_comb begin
    rnd_num   = '0;
    rnd_flags = 3'b000;
    if (e_r >= E_MAX) begin
      rnd_num   = {sign, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      rnd_flags = 3'b101;
    end else if (!sig_r[MANT_W-1]) begin
`ifdef FPU_PACK_FTZ_EN
      rnd_num = {sign, {(BITNESS-1){1'b0}}};
      if ((sig_r == '0) && !inexact)
        rnd_flags = 3'b000;
      else
        rnd_flags = 3'b011;
`else
      rnd_num   = {sign, {EXP_W{1'b0}}, sig_r[MANT_W-2:0]};
      rnd_flags = {1'b0, inexact, inexact};
`endif
    end else begin
      rnd_num   = {sign, e_r[EXP_W-1:0], sig_r[MANT_W-2:0]};
      rnd_flags = {2'b00, inexact};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      m          <= '0;
      e          <= '0;
      sign       <= 1'b0;
      out_number <= '0;
      out_flags  <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign <= in_sign;
            m    <= in_mant;
            e    <= in_exp;
            if (in_nan || in_inf || (in_mant == '0)) begin
              out_number <= spec_num;
              out_flags  <= 3'b000;
              state      <= S_DONE;
            end else begin
              state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (norm_done) begin
            state <= S_ROUND;
          end else begin
            m <= m_nx;
            e <= e_nx;
          end
        end
        S_ROUND: begin
          out_number <= rnd_num;
          out_flags  <= rnd_flags;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_pack.sv
// Directed self-checking bench for fpu_pack at BITNESS=32.
// Honors FPU_PACK_FTZ_EN for the denormal expectations.
module tb_fpu_pack;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_number;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;

  fpu_pack #(.BITNESS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_number (out_number),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operand, returns cycles from accept edge to out_valid (-1 on timeout).
  task automatic run_op(input logic s, input logic [9:0] ex, input logic [26:0] mt,
                        input logic nan, input logic inf, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_sign  = s;
    in_exp   = ex;
    in_mant  = mt;
    in_nan   = nan;
    in_inf   = inf;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_number !== 32'h0) begin errors++; $display("FAIL reset_out_number got=%h exp=00000000", out_number); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags got=%b exp=000", out_flags); end
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_normal();
    int lat;
    run_op(1'b0, 10'd127, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h3F800000) begin errors++; $display("FAIL one_number got=%h exp=3f800000", out_number); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL one_flags got=%b exp=000", out_flags); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL one_latency got=%0d exp=3", lat); end
    drain();
  endtask

  task automatic test_left_shift();
    int lat;
    run_op(1'b0, 10'd133, 27'h1 << 20, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h3F800000) begin errors++; $display("FAIL shift_number got=%h exp=3f800000", out_number); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL shift_latency got=%0d exp=9", lat); end
    drain();
  endtask

  task automatic test_rounding();
    int lat;
    run_op(1'b0, 10'd127, (27'h1 << 26) | (27'h1 << 2), 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h3F800000) begin errors++; $display("FAIL tie_even_number got=%h exp=3f800000", out_number); end
    checks++; if (out_flags !== 3'b001) begin errors++; $display("FAIL tie_even_flags got=%b exp=001", out_flags); end
    drain();
    run_op(1'b0, 10'd127, (27'h1 << 26) | (27'h1 << 3) | (27'h1 << 2), 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h3F800002) begin errors++; $display("FAIL tie_odd_number got=%h exp=3f800002", out_number); end
    checks++; if (out_flags !== 3'b001) begin errors++; $display("FAIL tie_odd_flags got=%b exp=001", out_flags); end
    drain();
    // all-ones significand with G=1 carries out into the next binade: 2.0
    run_op(1'b0, 10'd127, 27'h7FFFFFC, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h40000000) begin errors++; $display("FAIL carry_number got=%h exp=40000000", out_number); end
    checks++; if (out_flags !== 3'b001) begin errors++; $display("FAIL carry_flags got=%b exp=001", out_flags); end
    drain();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b0, 10'd255, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h7F800000) begin errors++; $display("FAIL ovf_number got=%h exp=7f800000", out_number); end
    checks++; if (out_flags !== 3'b101) begin errors++; $display("FAIL ovf_flags got=%b exp=101", out_flags); end
    drain();
    run_op(1'b1, 10'd254, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'hFF000000) begin errors++; $display("FAIL max_exp_number got=%h exp=ff000000", out_number); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL max_exp_flags got=%b exp=000", out_flags); end
    drain();
  endtask

  task automatic test_special();
    int lat;
    run_op(1'b1, 10'd5, 27'h123, 1'b1, 1'b1, lat);
    checks++; if (out_number !== 32'hFFC00000) begin errors++; $display("FAIL nan_number got=%h exp=ffc00000", out_number); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL nan_flags got=%b exp=000", out_flags); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL nan_latency got=%0d exp=1", lat); end
    drain();
    run_op(1'b0, 10'd5, 27'h123, 1'b0, 1'b1, lat);
    checks++; if (out_number !== 32'h7F800000) begin errors++; $display("FAIL inf_number got=%h exp=7f800000", out_number); end
    drain();
    run_op(1'b1, 10'd127, 27'h0, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h80000000) begin errors++; $display("FAIL zero_number got=%h exp=80000000", out_number); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    drain();
  endtask

  task automatic test_denormal();
    int lat;
    logic [31:0] exp_num;
    logic [2:0]  exp_flg;
`ifdef FPU_PACK_FTZ_EN
    exp_num = 32'h00000000; exp_flg = 3'b011;
`else
    exp_num = 32'h00400000; exp_flg = 3'b000;
`endif
    run_op(1'b0, 10'd0, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== exp_num) begin errors++; $display("FAIL denorm_number got=%h exp=%h", out_number, exp_num); end
    checks++; if (out_flags !== exp_flg) begin errors++; $display("FAIL denorm_flags got=%b exp=%b", out_flags, exp_flg); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL denorm_latency got=%0d exp=4", lat); end
    drain();
    // far below the denormal range: everything folds into sticky
    run_op(1'b1, 10'h3D8, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h80000000) begin errors++; $display("FAIL tiny_number got=%h exp=80000000", out_number); end
    checks++; if (out_flags !== 3'b011) begin errors++; $display("FAIL tiny_flags got=%b exp=011", out_flags); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(1'b0, 10'd127, (27'h1 << 26) | (27'h1 << 3) | (27'h1 << 2), 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_number !== 32'h3F800002) begin errors++; $display("FAIL hold_number cyc=%0d got=%h exp=3f800002", i, out_number); end
      checks++; if (out_flags !== 3'b001) begin errors++; $display("FAIL hold_flags cyc=%0d got=%b exp=001", i, out_flags); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
    end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL after_drain_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL after_drain_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    in_sign  = 1'b0;
    in_exp   = 10'd133;
    in_mant  = 27'h1 << 20;
    in_nan   = 1'b0;
    in_inf   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_norm_in_ready got=%b exp=0", in_ready); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output got=%b exp=0", out_valid); end
    run_op(1'b0, 10'd127, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h3F800000) begin errors++; $display("FAIL post_reset_number got=%h exp=3f800000", out_number); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 10'd128, 27'h1 << 26, 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'h40000000) begin errors++; $display("FAIL b2b_two got=%h exp=40000000", out_number); end
    drain();
    run_op(1'b1, 10'd127, (27'h1 << 26) | (27'h1 << 25), 1'b0, 1'b0, lat);
    checks++; if (out_number !== 32'hBFC00000) begin errors++; $display("FAIL b2b_neg_1p5 got=%h exp=bfc00000", out_number); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL b2b_neg_1p5_flags got=%b exp=000", out_flags); end
    drain();
    run_op(1'b0, 10'h3FF, 27'h1 << 26, 1'b0, 1'b0, lat);
`ifdef FPU_PACK_FTZ_EN
    checks++; if (out_number !== 32'h00000000) begin errors++; $display("FAIL b2b_denorm got=%h exp=00000000", out_number); end
`else
    checks++; if (out_number !== 32'h00200000) begin errors++; $display("FAIL b2b_denorm got=%h exp=00200000", out_number); end
`endif
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_denorm_latency got=%0d exp=5", lat); end
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_normal();
    test_left_shift();
    test_rounding();
    test_overflow();
    test_special();
    test_denormal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
